// File: rtl/fetch_unit_if.sv
// ----------------------------------------------------------------------------
// fetch_unit_if
//   Bundles the instruction-memory request/response channel, the redirect
//   input and the decode-side instruction channel of the fetch stage.
//
//   Signals:
//     imem_req_valid / imem_req_ready / imem_req_addr  fetch request channel
//     imem_rsp_valid / imem_rsp_data                   in-order response words
//     redirect / redirect_pc                           fetch restart pulse
//     inst_valid / inst_ready / inst / inst_pc         instruction to decode
//
//   Modports:
//     master : the fetch unit (drives requests and decode outputs)
//     slave  : the environment (memory, branch resolution, decoder)
// ----------------------------------------------------------------------------
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    modport master (
        output imem_req_valid,
        input  imem_req_ready,
        output imem_req_addr,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  redirect,
        input  redirect_pc,
        output inst_valid,
        input  inst_ready,
        output inst,
        output inst_pc
    );

    modport slave (
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_req_addr,
        output imem_rsp_valid,
        output imem_rsp_data,
        output redirect,
        output redirect_pc,
        input  inst_valid,
        output inst_ready,
        input  inst,
        input  inst_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage. Holds the PC, issues word-aligned requests to
//   instruction memory, pairs in-order response words with the PC of the
//   request that produced them, buffers them in a small queue and hands
//   {inst, inst_pc} to decode under valid/ready. A redirect pulse restarts
//   fetch at a new PC and discards everything queued or still in flight.
//
//   Parameters:
//     RESET_PC : first fetch address after reset (word aligned)
//     DEPTH    : queue entries; also the cap on outstanding + queued words
//
//   Ports:
//     clk   : clock, all state on the rising edge
//     rst_n : asynchronous active-low reset
//     bus   : fetch_unit_if.master (memory, redirect and decode channels)
// ----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus
);

    localparam int unsigned CW = $clog2(DEPTH + 1);            // counters 0..DEPTH
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SW = CW + 2;                       // sum of three counters
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    // Circular pointers need an explicit wrap because DEPTH need not be a
    // power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]   r_pc;
    logic [CW-1:0] r_outstanding;   // accepted requests whose word is still due
    logic [CW-1:0] r_drop;          // stale words still to arrive and be discarded
    logic [CW-1:0] r_count;         // instruction queue occupancy

    logic [31:0]   r_q_data [DEPTH];
    logic [31:0]   r_q_pc   [DEPTH];
    logic [PW-1:0] r_q_rd;
    logic [PW-1:0] r_q_wr;

    // Tag FIFO holding the PC of every outstanding request; its occupancy
    // is r_outstanding, so it needs no count of its own.
    logic [31:0]   r_tag_pc [DEPTH];
    logic [PW-1:0] r_tag_rd;
    logic [PW-1:0] r_tag_wr;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic [SW-1:0] w_inflight;
    logic          w_credit;
    logic          w_req_valid;
    logic          w_req_fire;
    logic          w_rsp_drop;
    logic          w_rsp_keep;
    logic          w_q_push;
    logic          w_inst_valid;
    logic          w_pop;
    logic [31:0]   w_redirect_pc;

    always_comb begin
        w_inflight    = SW'(r_outstanding) + SW'(r_drop) + SW'(r_count);
        w_credit      = (w_inflight < SW'(DEPTH));
        w_req_valid   = !bus.redirect && w_credit;
        w_req_fire    = w_req_valid && bus.imem_req_ready;
        w_rsp_drop    = bus.imem_rsp_valid && (r_drop != '0);
        w_rsp_keep    = bus.imem_rsp_valid && (r_drop == '0);
        w_q_push      = w_rsp_keep && !bus.redirect;
        w_inst_valid  = (r_count != '0);
        w_pop         = w_inst_valid && bus.inst_ready;
        w_redirect_pc = bus.redirect_pc & ~32'h0000_0003;
    end

    always_comb begin
        bus.imem_req_valid = w_req_valid;
        bus.imem_req_addr  = r_pc;
        bus.inst_valid     = w_inst_valid;
        bus.inst           = '0;
        bus.inst_pc        = '0;
        if (w_inst_valid) begin
            bus.inst    = r_q_data[r_q_rd];
            bus.inst_pc = r_q_pc[r_q_rd];
        end
    end

    // ------------------------------------------------------------------
    // PC, counters and pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_count       <= '0;
            r_q_rd        <= '0;
            r_q_wr        <= '0;
            r_tag_rd      <= '0;
            r_tag_wr      <= '0;
        end else if (bus.redirect) begin
            // Every word still owed by memory becomes stale. A word arriving
            // this same cycle is discarded here, whether it was already
            // stale or not, so it is taken off the total in both cases.
            r_pc          <= w_redirect_pc;
            r_drop        <= r_drop + r_outstanding - CW'(bus.imem_rsp_valid);
            r_outstanding <= '0;
            r_count       <= '0;
            r_q_rd        <= '0;
            r_q_wr        <= '0;
            r_tag_rd      <= '0;
            r_tag_wr      <= '0;
        end else begin
            if (w_req_fire) begin
                r_pc     <= r_pc + 32'd4;
                r_tag_wr <= ptr_inc(r_tag_wr);
            end
            r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_rsp_keep);
            r_drop        <= r_drop - CW'(w_rsp_drop);
            if (w_rsp_keep) begin
                r_tag_rd <= ptr_inc(r_tag_rd);
                r_q_wr   <= ptr_inc(r_q_wr);
            end
            if (w_pop) begin
                r_q_rd <= ptr_inc(r_q_rd);
            end
            r_count <= r_count + CW'(w_q_push) - CW'(w_pop);
        end
    end

    // ------------------------------------------------------------------
    // Storage (no reset needed: pointers and counts qualify every read)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_req_fire) begin
            r_tag_pc[r_tag_wr] <= r_pc;
        end
        if (w_q_push) begin
            r_q_data[r_q_wr] <= bus.imem_rsp_data;
            r_q_pc[r_q_wr]   <= r_tag_pc[r_tag_rd];
        end
    end

    // ------------------------------------------------------------------
    // Protocol sanity checks
    // ------------------------------------------------------------------
    a_no_queue_overflow: assert property (
        @(posedge clk) disable iff (!rst_n)
        (w_q_push && !w_pop) |-> (r_count < CW'(DEPTH)));

    a_rsp_was_requested: assert property (
        @(posedge clk) disable iff (!rst_n)
        bus.imem_rsp_valid |-> ((SW'(r_outstanding) + SW'(r_drop)) != '0));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    typedef struct {
        bit          rst;      // rst_n value
        bit          rdy;      // imem_req_ready
        bit          rv;       // imem_rsp_valid
        logic [31:0] rpc;      // address whose word is returned
        bit          rd;       // redirect
        logic [31:0] rdpc;     // redirect_pc
        bit          ir;       // inst_ready
        bit          e_rv;     // expected imem_req_valid
        logic [31:0] e_addr;   // expected imem_req_addr
        bit          e_iv;     // expected inst_valid
        logic [31:0] e_ipc;    // expected inst_pc when valid
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    vec_t vecs[$];

    fetch_unit_if bif ();

    fetch_unit #(.RESET_PC(32'h0000_0100), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory content: each word is a fixed function of its address.
    function automatic logic [31:0] fdat(input logic [31:0] a);
        return a ^ 32'hA5A5_A5A5;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s (step %0d): got %h, need %h", nm, idx, got, exp);
    endtask

    task automatic add(input bit rst, input bit rdy, input bit rv, input logic [31:0] rpc,
                       input bit rd, input logic [31:0] rdpc, input bit ir,
                       input bit e_rv, input logic [31:0] e_addr, input bit e_iv, input logic [31:0] e_ipc);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.rd = rd; v.rdpc = rdpc; v.ir = ir;
        v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_ipc = e_ipc;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] exp_req;
        int unsigned cyc;
        int unsigned last_due;
        int unsigned due;
        int unsigned pend_due[$];
        logic [31:0] pend_addr[$];
        int          got_n;

        n_checks = 0;
        n_pass   = 0;
        rst_n = 1'b0;
        bif.imem_req_ready = 1'b0;
        bif.imem_rsp_valid = 1'b0;
        bif.imem_rsp_data  = '0;
        bif.redirect       = 1'b0;
        bif.redirect_pc    = '0;
        bif.inst_ready     = 1'b0;

        //   rst rdy rv rsp_pc         rd rd_pc          ir  e_rv e_addr         e_iv e_ipc
        // Start-up with 1-cycle memory
        add(1, 1, 0, 32'h0,          0, 32'h0,          1,  1, 32'h0000_0100, 0, 32'h0);          // 0
        add(1, 1, 1, 32'h0000_0100,  0, 32'h0,          1,  1, 32'h0000_0104, 0, 32'h0);          // 1
        add(1, 1, 1, 32'h0000_0104,  0, 32'h0,          1,  0, 32'h0000_0108, 1, 32'h0000_0100);  // 2
        add(1, 1, 0, 32'h0,          0, 32'h0,          1,  1, 32'h0000_0108, 1, 32'h0000_0104);  // 3
        add(1, 1, 1, 32'h0000_0108,  0, 32'h0,          1,  1, 32'h0000_010C, 0, 32'h0);          // 4
        add(1, 1, 1, 32'h0000_010C,  0, 32'h0,          1,  0, 32'h0000_0110, 1, 32'h0000_0108);  // 5
        add(1, 1, 0, 32'h0,          0, 32'h0,          1,  1, 32'h0000_0110, 1, 32'h0000_010C);  // 6
        // Decode stalls: queue fills, requests stop, nothing lost on release
        add(1, 1, 1, 32'h0000_0110,  0, 32'h0,          0,  1, 32'h0000_0114, 0, 32'h0);          // 7
        add(1, 1, 1, 32'h0000_0114,  0, 32'h0,          0,  0, 32'h0000_0118, 1, 32'h0000_0110);  // 8
        add(1, 1, 0, 32'h0,          0, 32'h0,          0,  0, 32'h0000_0118, 1, 32'h0000_0110);  // 9
        add(1, 1, 0, 32'h0,          0, 32'h0,          0,  0, 32'h0000_0118, 1, 32'h0000_0110);  // 10
        add(1, 1, 0, 32'h0,          0, 32'h0,          1,  0, 32'h0000_0118, 1, 32'h0000_0110);  // 11
        add(1, 1, 0, 32'h0,          0, 32'h0,          1,  1, 32'h0000_0118, 1, 32'h0000_0114);  // 12
        add(1, 1, 1, 32'h0000_0118,  0, 32'h0,          1,  1, 32'h0000_011C, 0, 32'h0);          // 13
        add(1, 1, 0, 32'h0,          0, 32'h0,          1,  0, 32'h0000_0120, 1, 32'h0000_0118);  // 14
        add(1, 1, 0, 32'h0,          0, 32'h0,          1,  1, 32'h0000_0120, 0, 32'h0);          // 15
        // Redirect to 0x203 with 0x11C and 0x120 in flight
        add(1, 1, 0, 32'h0,          1, 32'h0000_0203,  1,  0, 32'h0000_0124, 0, 32'h0);          // 16
        add(1, 1, 1, 32'h0000_011C,  0, 32'h0,          1,  0, 32'h0000_0200, 0, 32'h0);          // 17
        add(1, 1, 1, 32'h0000_0120,  0, 32'h0,          1,  1, 32'h0000_0200, 0, 32'h0);          // 18
        add(1, 1, 1, 32'h0000_0200,  0, 32'h0,          1,  1, 32'h0000_0204, 0, 32'h0);          // 19
        add(1, 1, 1, 32'h0000_0204,  0, 32'h0,          1,  0, 32'h0000_0208, 1, 32'h0000_0200);  // 20
        add(1, 1, 0, 32'h0,          0, 32'h0,          1,  1, 32'h0000_0208, 1, 32'h0000_0204);  // 21
        add(1, 1, 1, 32'h0000_0208,  0, 32'h0,          1,  1, 32'h0000_020C, 0, 32'h0);          // 22
        // Redirect coincident with a live response and a decode pop
        add(1, 1, 1, 32'h0000_020C,  1, 32'h0000_0300,  1,  0, 32'h0000_0210, 1, 32'h0000_0208);  // 23
        add(1, 1, 0, 32'h0,          0, 32'h0,          1,  1, 32'h0000_0300, 0, 32'h0);          // 24
        add(1, 1, 1, 32'h0000_0300,  0, 32'h0,          1,  1, 32'h0000_0304, 0, 32'h0);          // 25
        add(1, 1, 0, 32'h0,          0, 32'h0,          1,  0, 32'h0000_0308, 1, 32'h0000_0300);  // 26
        add(1, 1, 1, 32'h0000_0304,  0, 32'h0,          1,  1, 32'h0000_0308, 0, 32'h0);          // 27
        // Back-to-back redirects while stale words are pending
        add(1, 1, 0, 32'h0,          1, 32'h0000_0400,  1,  0, 32'h0000_030C, 1, 32'h0000_0304);  // 28
        add(1, 1, 0, 32'h0,          0, 32'h0,          1,  1, 32'h0000_0400, 0, 32'h0);          // 29
        add(1, 1, 0, 32'h0,          1, 32'h0000_0500,  1,  0, 32'h0000_0404, 0, 32'h0);          // 30
        add(1, 1, 1, 32'h0000_0308,  0, 32'h0,          1,  0, 32'h0000_0500, 0, 32'h0);          // 31
        add(1, 1, 1, 32'h0000_0400,  0, 32'h0,          1,  1, 32'h0000_0500, 0, 32'h0);          // 32
        add(1, 1, 1, 32'h0000_0500,  0, 32'h0,          1,  1, 32'h0000_0504, 0, 32'h0);          // 33
        add(1, 1, 0, 32'h0,          0, 32'h0,          1,  0, 32'h0000_0508, 1, 32'h0000_0500);  // 34
        add(1, 1, 1, 32'h0000_0504,  0, 32'h0,          1,  1, 32'h0000_0508, 0, 32'h0);          // 35
        add(1, 1, 0, 32'h0,          0, 32'h0,          1,  0, 32'h0000_050C, 1, 32'h0000_0504);  // 36
        add(1, 1, 1, 32'h0000_0508,  0, 32'h0,          1,  1, 32'h0000_050C, 0, 32'h0);          // 37
        add(1, 1, 1, 32'h0000_050C,  0, 32'h0,          1,  0, 32'h0000_0510, 1, 32'h0000_0508);  // 38
        add(1, 1, 0, 32'h0,          0, 32'h0,          1,  1, 32'h0000_0510, 1, 32'h0000_050C);  // 39
        // Memory not ready: request held, PC not advanced
        add(1, 0, 0, 32'h0,          0, 32'h0,          1,  1, 32'h0000_0514, 0, 32'h0);          // 40
        add(1, 0, 1, 32'h0000_0510,  0, 32'h0,          1,  1, 32'h0000_0514, 0, 32'h0);          // 41
        add(1, 1, 0, 32'h0,          0, 32'h0,          1,  1, 32'h0000_0514, 1, 32'h0000_0510);  // 42
        // Reset mid-operation takes effect immediately
        add(0, 1, 0, 32'h0,          0, 32'h0,          1,  1, 32'h0000_0100, 0, 32'h0);          // 43
        // PC wrap; redirect_pc low bits forced to zero
        add(1, 1, 0, 32'h0,          1, 32'hFFFF_FFFF,  1,  0, 32'h0000_0100, 0, 32'h0);          // 44
        add(1, 1, 0, 32'h0,          0, 32'h0,          1,  1, 32'hFFFF_FFFC, 0, 32'h0);          // 45
        add(1, 1, 1, 32'hFFFF_FFFC,  0, 32'h0,          1,  1, 32'h0000_0000, 0, 32'h0);          // 46
        add(1, 1, 1, 32'h0000_0000,  0, 32'h0,          1,  0, 32'h0000_0004, 1, 32'hFFFF_FFFC);  // 47
        add(1, 1, 0, 32'h0,          0, 32'h0,          1,  1, 32'h0000_0004, 1, 32'h0000_0000);  // 48

        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_n              = vecs[i].rst;
            bif.imem_req_ready = vecs[i].rdy;
            bif.imem_rsp_valid = vecs[i].rv;
            bif.imem_rsp_data  = vecs[i].rv ? fdat(vecs[i].rpc) : 32'hDEAD_BEEF;
            bif.redirect       = vecs[i].rd;
            bif.redirect_pc    = vecs[i].rdpc;
            bif.inst_ready     = vecs[i].ir;
            #1;
            chk("req_valid",  i, 32'(bif.imem_req_valid), 32'(vecs[i].e_rv));
            chk("req_addr",   i, bif.imem_req_addr, vecs[i].e_addr);
            chk("inst_valid", i, 32'(bif.inst_valid), 32'(vecs[i].e_iv));
            chk("inst_pc",    i, bif.inst_pc, vecs[i].e_iv ? vecs[i].e_ipc : 32'h0);
            chk("inst",       i, bif.inst, vecs[i].e_iv ? fdat(vecs[i].e_ipc) : 32'h0);
        end

        // Random memory stalls and 1-4 cycle in-order latency against a
        // sequential PC reference.
        @(negedge clk);
        rst_n = 1'b0;
        bif.imem_rsp_valid = 1'b0;
        bif.redirect = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_pc   = 32'h0000_0100;
        exp_req  = 32'h0000_0100;
        cyc      = 0;
        last_due = 0;
        got_n    = 0;
        for (int c = 0; c < 3000 && got_n < 200; c++) begin
            if (c != 0) @(negedge clk);
            cyc++;
            if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                bif.imem_rsp_valid = 1'b1;
                bif.imem_rsp_data  = fdat(pend_addr[0]);
                void'(pend_due.pop_front());
                void'(pend_addr.pop_front());
            end else begin
                bif.imem_rsp_valid = 1'b0;
                bif.imem_rsp_data  = 32'hDEAD_BEEF;
            end
            bif.imem_req_ready = ($urandom_range(0, 3) != 0);
            bif.inst_ready     = ($urandom_range(0, 3) != 0);
            #1;
            if (bif.imem_req_valid && bif.imem_req_ready) begin
                chk("rnd_req_addr", c, bif.imem_req_addr, exp_req);
                exp_req = exp_req + 32'd4;
                due = cyc + $urandom_range(1, 4);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                pend_due.push_back(due);
                pend_addr.push_back(bif.imem_req_addr);
            end
            if (bif.inst_valid && bif.inst_ready) begin
                chk("rnd_inst_pc", c, bif.inst_pc, exp_pc);
                chk("rnd_inst",    c, bif.inst, fdat(exp_pc));
                exp_pc = exp_pc + 32'd4;
                got_n++;
            end
        end
        chk("rnd_delivered", 0, 32'(got_n), 32'd200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
